// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of the async FIFO (rclk domain).
// Pops DATASIZE-bit entries from a show-ahead FIFO and packs PACK of them
// into one wide word. The word is presented on a valid/ready port. A flush
// pulse emits a partially filled word early.
//
// Handshake: a word transfers on any rclk edge where out_valid=1 and
// out_ready=1. Once out_valid rises, out_data/out_cnt stay stable until that
// transfer. On the FIFO side, an entry is consumed on every edge with rinc=1.
// rinc is only raised when rempty=0.
module fifo_rd_packer #(
  parameter  int DATASIZE = 8,
  parameter  int PACK     = 4,
  localparam int CW       = $clog2(PACK + 1)
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic                     rempty,
  input  logic [DATASIZE-1:0]      rdata,
  output logic                     rinc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATASIZE*PACK-1:0] out_data,
  output logic [CW-1:0]            out_cnt
);

  localparam int IW = $clog2(PACK);
  localparam int OW = DATASIZE * PACK;
  localparam logic [IW-1:0] LAST_IDX = IW'(PACK - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] k;
  logic [OW-1:0] captured;
  logic [OW-1:0] flushed;
  logic [OW-1:0] restart;

  // Pop whenever data is present and there is room: while filling, or while
  // the held word is being accepted in this same cycle.
  always_comb begin
    rinc = rrst_n & ~rempty & ((state == FILL) | out_ready);
  end

  // Next-buffer candidates: this cycle's capture, the flushed version with
  // unused lanes cleared, and a fresh buffer that starts with the popped entry.
  always_comb begin
    k        = CW'(idx) + CW'(rinc);
    captured = out_data;
    if (rinc) begin
      captured[idx*DATASIZE +: DATASIZE] = rdata;
    end
    flushed = '0;
    for (int l = 0; l < PACK; l++) begin
      if (CW'(l) < k) begin
        flushed[l*DATASIZE +: DATASIZE] = captured[l*DATASIZE +: DATASIZE];
      end
    end
    restart = OW'(rdata);
  end

  // FILL/HOLD controller. All outputs are registered here.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= FILL;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (rinc && (idx == LAST_IDX)) begin
            out_data  <= captured;
            out_cnt   <= CW'(PACK);
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= HOLD;
          end else if (flush && (k != '0)) begin
            out_data  <= flushed;
            out_cnt   <= k;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= HOLD;
          end else if (rinc) begin
            out_data <= captured;
            idx      <= idx + IW'(1);
          end
        end
        HOLD: begin
          // A flush arriving here is dropped on purpose.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FILL;
            if (rinc) begin
              out_data <= restart;
              idx      <= IW'(1);
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer. A reference model tracks the source FIFO as a
// queue, the entries collected so far, and the word on offer. It checks rinc
// and the output port every cycle.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int CW = $clog2(PK + 1);

  // ---------------- clock / reset ----------------
  logic              rclk = 1'b0;
  logic              rrst_n;
  logic              rempty;
  logic [DW-1:0]     rdata;
  logic              rinc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DW*PK-1:0]  out_data;
  logic [CW-1:0]     out_cnt;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DATASIZE(DW), .PACK(PK)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  // ---------------- scoreboard / model ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] src_q[$];   // entries sitting in the FIFO, head first
  logic [DW-1:0] cur_q[$];   // entries collected into the partial word
  bit            m_hold = 1'b0;
  logic [DW*PK-1:0] m_word = '0;
  int            m_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW*PK-1:0] pack_word(input logic [DW-1:0] q[$]);
    logic [DW*PK-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w = w | ((DW*PK)'(q[i]) << (i * DW));
    return w;
  endfunction

  // ---------------- driver ----------------
  // One rclk cycle: drive inputs at negedge, check, then advance the model.
  task automatic cycle(input bit stall, input bit rdy, input bit fl);
    bit            e;
    bit            exp_rinc;
    logic [DW-1:0] head;
    @(negedge rclk);
    e    = (src_q.size() == 0) || stall;
    head = (src_q.size() != 0) ? src_q[0] : DW'($urandom);
    rempty    = e;
    rdata     = head;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_rinc = !e && (!m_hold || rdy);
    check_val("rinc", 64'(rinc), 64'(exp_rinc));
    check_val("out_valid", 64'(out_valid), 64'(m_hold));
    if (m_hold) begin
      check_val("out_data", 64'(out_data), 64'(m_word));
      check_val("out_cnt", 64'(out_cnt), 64'(m_cnt));
    end
    @(posedge rclk);
    if (m_hold) begin
      if (rdy) begin
        m_hold = 1'b0;
        cur_q.delete();
        if (exp_rinc) cur_q.push_back(head);
      end
    end else begin
      if (exp_rinc) cur_q.push_back(head);
      if (cur_q.size() == PK || (fl && cur_q.size() != 0)) begin
        m_word = pack_word(cur_q);
        m_cnt  = cur_q.size();
        m_hold = 1'b1;
        cur_q.delete();
      end
    end
    if (exp_rinc) void'(src_q.pop_front());
  endtask

  task automatic model_reset();
    cur_q.delete();
    m_hold = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rrst_n = 1'b0; rempty = 1'b0; rdata = 8'h5A; flush = 1'b0; out_ready = 1'b0;
    #12;
    check_val("rst_rinc", 64'(rinc), 64'd0);
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_data", 64'(out_data), 64'd0);
    check_val("rst_cnt", 64'(out_cnt), 64'd0);
    @(negedge rclk); rrst_n = 1'b1; rempty = 1'b1;

    // back-to-back word, accepted at once
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    #1 check_val("t2_data", 64'(out_data), 64'h44332211);
    check_val("t2_cnt", 64'(out_cnt), 64'd4);
    cycle(0, 1, 0);
    cycle(0, 1, 0);

    // backpressure: exactly four pops, then accept + pop in the same cycle
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 7; i++) cycle(0, 0, 0);
    check_val("t3_left", 64'(src_q.size()), 64'd4);
    #1 check_val("t3_data0", 64'(out_data), 64'h04030201);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    #1 check_val("t3_data1", 64'(out_data), 64'h08070605);
    cycle(0, 1, 0);

    // flush of a partial word; flush of an empty buffer does nothing
    src_q = '{8'hAA, 8'hBB};
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 1);
    #1 check_val("t4_data", 64'(out_data), 64'h0000BBAA);
    check_val("t4_cnt", 64'(out_cnt), 64'd2);
    cycle(0, 1, 0);
    cycle(0, 0, 1);
    #1 check_val("t4_noword", 64'(out_valid), 64'd0);
    cycle(0, 1, 0);

    // flush coinciding with the fourth pop
    src_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 1);
    #1 check_val("t5_data", 64'(out_data), 64'hDDCCBBAA);
    check_val("t5_cnt", 64'(out_cnt), 64'd4);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 1);

    // reset in the middle of a partial word
    src_q = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    @(negedge rclk);
    rempty = 1'b0;
    rrst_n = 1'b0;
    #1;
    check_val("t6_rst_rinc", 64'(rinc), 64'd0);
    check_val("t6_rst_valid", 64'(out_valid), 64'd0);
    check_val("t6_rst_data", 64'(out_data), 64'd0);
    model_reset();
    @(negedge rclk); rrst_n = 1'b1; rempty = 1'b1;
    src_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    #1 check_val("t6_data", 64'(out_data), 64'h40302010);
    check_val("t6_cnt", 64'(out_cnt), 64'd4);
    cycle(0, 1, 0);

    // randomized traffic: stalls, backpressure, flushes
    for (int i = 0; i < 2000; i++) begin
      while (src_q.size() < 3) src_q.push_back(DW'($urandom));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end
    // drain
    src_q.delete();
    for (int i = 0; i < 4; i++) cycle(0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
